// File: rtl/cosim_stim_pkg.sv
// Shared types and helpers for the cosim stimulus generator / response checker.
package cosim_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST1,
        REL1,
        RAND,
        RST2,
        REL2,
        DIR,
        DONE
    } cosim_state_e;

    // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One right-shift Galois step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] shifted;
        shifted = cur >> 1;
        lfsr_next = cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    // Number of cycles a state holds one vector before moving on.
    function automatic int unsigned phase_len(input cosim_state_e st, input int unsigned hold);
        case (st)
            RST1, RST2, RAND, DIR: phase_len = hold;
            default:               phase_len = 1;
        endcase
    endfunction

endpackage

// File: rtl/cosim_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable.
module cosim_lfsr32
    import cosim_stim_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h1234_5678
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    // Load takes priority over step so a fresh run always begins at the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/cosim_stim_checker.sv
// Stimulus generator and golden/netlist response checker for on-board
// equivalence runs. Optional first-mismatch capture: COSIM_FIRST_FAIL_CAPTURE_EN.
module cosim_stim_checker
    import cosim_stim_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUM_VECTORS  = 1000,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter logic [31:0] LFSR_SEED    = 32'h1234_5678,
    parameter logic [31:0] DIRECTED_VEC = 32'hABCD_EFAB,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_rst,
    output logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] golden_out,
    input  logic [WIDTH-1:0] netlist_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] vec_idx,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_golden,
    output logic [WIDTH-1:0] first_fail_netlist
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cosim_stim_checker: WIDTH must be in 1..32");
    end
    if (NUM_VECTORS < 1) begin : g_bad_vectors
        $error("cosim_stim_checker: NUM_VECTORS must be at least 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("cosim_stim_checker: HOLD_CYCLES must be at least 1");
    end
    if (LFSR_SEED == 32'h0) begin : g_bad_seed
        $error("cosim_stim_checker: LFSR_SEED must be nonzero");
    end
    if ((64'(NUM_VECTORS) + 64'd2) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("cosim_stim_checker: NUM_VECTORS+2 does not fit in CNT_W bits");
    end

    cosim_state_e      state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0]  idx_nxt, mis_nxt;
    logic              busy_nxt, done_nxt, pass_nxt, dut_rst_nxt;
    logic [WIDTH-1:0]  stim_nxt;
    logic              last, cmp, mismatch, run_start, lfsr_step;
    logic [31:0]       lfsr_q, lfsr_peek;

    cosim_lfsr32 #(
        .RESET_VAL(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (run_start),
        .seed (LFSR_SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign mismatch = (golden_out != netlist_out);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencing, compare decision and next values of every registered output.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        idx_nxt   = vec_idx;
        mis_nxt   = mismatch_cnt;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass;
        cmp       = 1'b0;
        run_start = 1'b0;
        lfsr_step = 1'b0;
        last      = (hold_cnt == HOLD_W'(phase_len(state, HOLD_CYCLES) - 1));

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RST1;
                    run_start = 1'b1;
                    hold_nxt  = '0;
                    idx_nxt   = '0;
                    mis_nxt   = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end
            end
            RST1, RST2, RAND, DIR: begin
                if (last) begin
                    cmp      = 1'b1;
                    hold_nxt = '0;
                    case (state)
                        RST1: begin
                            state_nxt = REL1;
                            idx_nxt   = vec_idx + 1'b1;
                        end
                        RST2: begin
                            state_nxt = REL2;
                            idx_nxt   = vec_idx + 1'b1;
                        end
                        RAND: begin
                            lfsr_step = 1'b1;
                            idx_nxt   = vec_idx + 1'b1;
                            if (vec_idx == CNT_W'(NUM_VECTORS)) begin
                                state_nxt = RST2;
                            end
                        end
                        default: begin
                            state_nxt = DONE;
                        end
                    endcase
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            REL1: begin
                state_nxt = RAND;
                hold_nxt  = '0;
            end
            REL2: begin
                state_nxt = DIR;
                hold_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (cmp && mismatch && (mismatch_cnt != '1)) begin
            mis_nxt = mismatch_cnt + 1'b1;
        end

        // pass must account for the final directed compare happening this cycle.
        if (cmp && (state == DIR)) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
            pass_nxt = (mis_nxt == '0);
        end

        dut_rst_nxt = (state_nxt == IDLE) || (state_nxt == RST1) ||
                      (state_nxt == RST2) || (state_nxt == DONE);

        // stim is registered, so it takes the value the LFSR moves to at this edge.
        lfsr_peek = lfsr_step ? lfsr_next(lfsr_q) : lfsr_q;
        stim_nxt  = '0;
        if (state_nxt == RAND) begin
            stim_nxt = lfsr_peek[WIDTH-1:0];
        end else if (state_nxt == DIR) begin
            stim_nxt = DIRECTED_VEC[WIDTH-1:0];
        end
    end

    // Registered outputs, counters and the hold-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt     <= '0;
            vec_idx      <= '0;
            mismatch_cnt <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            dut_rst      <= 1'b1;
            stim         <= '0;
        end else begin
            hold_cnt     <= hold_nxt;
            vec_idx      <= idx_nxt;
            mismatch_cnt <= mis_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            dut_rst      <= dut_rst_nxt;
            stim         <= stim_nxt;
        end
    end

`ifdef COSIM_FIRST_FAIL_CAPTURE_EN
    logic ff_seen;

    // Latch the index and both responses of the first mismatch in a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_seen            <= 1'b0;
            first_fail_idx     <= '0;
            first_fail_golden  <= '0;
            first_fail_netlist <= '0;
        end else if (run_start) begin
            ff_seen            <= 1'b0;
            first_fail_idx     <= '0;
            first_fail_golden  <= '0;
            first_fail_netlist <= '0;
        end else if (cmp && mismatch && !ff_seen) begin
            ff_seen            <= 1'b1;
            first_fail_idx     <= vec_idx;
            first_fail_golden  <= golden_out;
            first_fail_netlist <= netlist_out;
        end
    end
`else
    assign first_fail_idx     = '0;
    assign first_fail_golden  = '0;
    assign first_fail_netlist = '0;
`endif

endmodule
